// File: rtl/upd7800_clkgen.sv
// Two-phase clock and reset sequencer for the uPD7800 core: divides clk_i into
// four quarters per CPU state, emits CP1/CP2 levels and edge strobes, and stretches reset.
module upd7800_clkgen #(
    parameter int DIV        = 3,
    parameter int RST_STATES = 8
) (
    input  logic clk_i,
    input  logic resetb_i,
    input  logic ext_resb_i,
    input  logic hold_req_i,
    output logic hold_ack_o,
    output logic cp1_o,
    output logic cp2_o,
    output logic cp1_posedge_o,
    output logic cp1_negedge_o,
    output logic cp2_posedge_o,
    output logic cp2_negedge_o,
    output logic cpu_resetb_o
);

    localparam int QW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW = $clog2(RST_STATES + 1);
    localparam logic [QW-1:0] QMAX = QW'(DIV - 1);
    localparam logic [RW-1:0] RMAX = RW'(RST_STATES);

    typedef enum logic [1:0] {Q0 = 2'd0, Q1 = 2'd1, Q2 = 2'd2, Q3 = 2'd3} quarter_t;

    quarter_t        quarter_q, quarter_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
    logic            run_q, hold_q, hold_d;
    logic            ext_s1_q, ext_s2_q;
    logic            cp1_q, cp1_d, cp2_q, cp2_d;
    logic            p1p_q, p1p_d, p1n_q, p1n_d, p2p_q, p2p_d, p2n_q, p2n_d;
    logic            cpu_resetb_q, cpu_resetb_d;
    logic            enter;

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            quarter_q    <= Q3;
            qcnt_q       <= '0;
            rst_cnt_q    <= '0;
            run_q        <= 1'b0;
            hold_q       <= 1'b0;
            ext_s1_q     <= 1'b0;
            ext_s2_q     <= 1'b0;
            cp1_q        <= 1'b0;
            cp2_q        <= 1'b0;
            p1p_q        <= 1'b0;
            p1n_q        <= 1'b0;
            p2p_q        <= 1'b0;
            p2n_q        <= 1'b0;
            cpu_resetb_q <= 1'b0;
        end else begin
            quarter_q    <= quarter_d;
            qcnt_q       <= qcnt_d;
            rst_cnt_q    <= rst_cnt_d;
            run_q        <= 1'b1;
            hold_q       <= hold_d;
            ext_s1_q     <= ext_resb_i;
            ext_s2_q     <= ext_s1_q;
            cp1_q        <= cp1_d;
            cp2_q        <= cp2_d;
            p1p_q        <= p1p_d;
            p1n_q        <= p1n_d;
            p2p_q        <= p2p_d;
            p2n_q        <= p2n_d;
            cpu_resetb_q <= cpu_resetb_d;
        end
    end

    always_comb begin
        quarter_d = quarter_q;
        qcnt_d    = qcnt_q;
        hold_d    = hold_q;
        enter     = 1'b0;
        if (!run_q) begin
            // First edge out of reset always lands on the start of Q0.
            quarter_d = Q0;
            qcnt_d    = '0;
            hold_d    = 1'b0;
            enter     = 1'b1;
        end else if (qcnt_q == QMAX) begin
            if (quarter_q == Q3 && hold_req_i) begin
                hold_d = 1'b1;
            end else begin
                quarter_d = quarter_t'(quarter_q + 2'd1);
                qcnt_d    = '0;
                hold_d    = 1'b0;
                enter     = 1'b1;
            end
        end else begin
            qcnt_d = qcnt_q + QW'(1);
        end

        cp1_d = (quarter_d == Q0);
        cp2_d = (quarter_d == Q2);
        p1p_d = enter && (quarter_d == Q0);
        p1n_d = enter && (quarter_d == Q1);
        p2p_d = enter && (quarter_d == Q2);
        p2n_d = enter && (quarter_d == Q3);

        // Count completed CPU states, including the one whose P2- strobe is visible now.
        rst_cnt_d = rst_cnt_q;
        if (!ext_s2_q) begin
            rst_cnt_d = '0;
        end else if (p2n_q && rst_cnt_q != RMAX) begin
            rst_cnt_d = rst_cnt_q + RW'(1);
        end

        cpu_resetb_d = ext_s2_q && (cpu_resetb_q || (rst_cnt_d == RMAX && p1p_d));
    end

    assign hold_ack_o    = hold_q;
    assign cp1_o         = cp1_q;
    assign cp2_o         = cp2_q;
    assign cp1_posedge_o = p1p_q;
    assign cp1_negedge_o = p1n_q;
    assign cp2_posedge_o = p2p_q;
    assign cp2_negedge_o = p2n_q;
    assign cpu_resetb_o  = cpu_resetb_q;

endmodule

// File: tb/tb_upd7800_clkgen.sv
// Directed bench for upd7800_clkgen: a DIV=3 instance for cadence, reset stretch,
// soft reset, hold and async reset, plus a DIV=1 instance checked alongside the start-up table.
module tb_upd7800_clkgen;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    logic ext_resb = 1'b1;
    logic hold_req = 1'b0;

    logic hold_ack, cp1, cp2, p1p, p1n, p2p, p2n, cpu_resetb;
    logic hold_ack1, cp1_1, cp2_1, p1p1, p1n1, p2p1, p2n1, cpu_resetb1;
    logic [7:0] obs, obs1;

    int n_checks = 0;
    int n_pass   = 0;
    int k        = 0;

    always #5 clk = ~clk;

    upd7800_clkgen #(.DIV(3), .RST_STATES(8)) u_dut (
        .clk_i(clk), .resetb_i(resetb), .ext_resb_i(ext_resb), .hold_req_i(hold_req),
        .hold_ack_o(hold_ack), .cp1_o(cp1), .cp2_o(cp2),
        .cp1_posedge_o(p1p), .cp1_negedge_o(p1n), .cp2_posedge_o(p2p), .cp2_negedge_o(p2n),
        .cpu_resetb_o(cpu_resetb)
    );

    upd7800_clkgen #(.DIV(1), .RST_STATES(2)) u_dut1 (
        .clk_i(clk), .resetb_i(resetb), .ext_resb_i(ext_resb), .hold_req_i(hold_req),
        .hold_ack_o(hold_ack1), .cp1_o(cp1_1), .cp2_o(cp2_1),
        .cp1_posedge_o(p1p1), .cp1_negedge_o(p1n1), .cp2_posedge_o(p2p1), .cp2_negedge_o(p2n1),
        .cpu_resetb_o(cpu_resetb1)
    );

    // Bit order: {hold_ack, cp1, cp2, p1+, p1-, p2+, p2-, cpu_resetb}
    assign obs  = {hold_ack, cp1, cp2, p1p, p1n, p2p, p2n, cpu_resetb};
    assign obs1 = {hold_ack1, cp1_1, cp2_1, p1p1, p1n1, p2p1, p2n1, cpu_resetb1};

    typedef struct {
        logic       hold_req;
        logic       ext_resb;
        logic [7:0] exp;
        logic [7:0] exp1;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (k=%0d): got %b expected %b", name, k, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        check("no_overlap", {7'b0, cp1 & cp2}, 8'b0);
    endtask

    task automatic tick_to(input int target);
        while (k < target) tick();
    endtask

    task automatic run_table();
        for (int i = 0; i < 13; i++) begin
            hold_req = vecs[i].hold_req;
            ext_resb = vecs[i].ext_resb;
            tick();
            check($sformatf("vec%0d_div3", i + 1), obs, vecs[i].exp);
            check($sformatf("vec%0d_div1", i + 1), obs1, vecs[i].exp1);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetb = 1'b1;
        k = 0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 8'b0101_0000, 8'b0101_0000};
        vecs[1]  = '{1'b0, 1'b1, 8'b0100_0000, 8'b0000_1000};
        vecs[2]  = '{1'b0, 1'b1, 8'b0100_0000, 8'b0010_0100};
        vecs[3]  = '{1'b0, 1'b1, 8'b0000_1000, 8'b0000_0010};
        vecs[4]  = '{1'b0, 1'b1, 8'b0000_0000, 8'b0101_0000};
        vecs[5]  = '{1'b0, 1'b1, 8'b0000_0000, 8'b0000_1000};
        vecs[6]  = '{1'b0, 1'b1, 8'b0010_0100, 8'b0010_0100};
        vecs[7]  = '{1'b0, 1'b1, 8'b0010_0000, 8'b0000_0010};
        vecs[8]  = '{1'b0, 1'b1, 8'b0010_0000, 8'b0101_0001};
        vecs[9]  = '{1'b0, 1'b1, 8'b0000_0010, 8'b0000_1001};
        vecs[10] = '{1'b0, 1'b1, 8'b0000_0000, 8'b0010_0101};
        vecs[11] = '{1'b0, 1'b1, 8'b0000_0000, 8'b0000_0011};
        vecs[12] = '{1'b0, 1'b1, 8'b0101_0000, 8'b0101_0001};

        // Held in reset: everything low, even with hold requested.
        hold_req = 1'b1;
        repeat (4) tick();
        check("reset_div3", obs, 8'b0);
        check("reset_div1", obs1, 8'b0);
        hold_req = 1'b0;

        // Start-up cadence for both instances.
        release_reset();
        run_table();

        // Reset stretch: 8th P2- at k=94, release with P1+ at k=97.
        tick_to(96);
        check("cpu_resetb_k96", {7'b0, cpu_resetb}, 8'b0);
        tick_to(97);
        check("release_k97", obs, 8'b0101_0001);

        // Soft reset pulse of 5 clocks starting after the k=100 sample.
        tick_to(100);
        ext_resb = 1'b0;
        tick_to(102);
        check("soft_rst_k102", {7'b0, cpu_resetb}, 8'b1);
        tick_to(103);
        check("soft_rst_k103", {7'b0, cpu_resetb}, 8'b0);
        tick_to(105);
        ext_resb = 1'b1;
        tick_to(106);
        check("cadence_p2n_k106", obs, 8'b0000_0010);
        tick_to(109);
        check("cadence_p1p_k109", obs, 8'b0101_0000);
        tick_to(204);
        check("soft_hold_k204", {7'b0, cpu_resetb}, 8'b0);
        tick_to(205);
        check("soft_release_k205", obs, 8'b0101_0001);

        // Hold requested during Q1: the state completes, then parks.
        tick_to(208);
        check("q1_k208", obs, 8'b0000_1001);
        hold_req = 1'b1;
        tick_to(211);
        check("hold_p2p_k211", obs, 8'b0010_0101);
        tick_to(214);
        check("hold_p2n_k214", obs, 8'b0000_0011);
        tick_to(216);
        check("hold_last_q3_k216", obs, 8'b0000_0001);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("parked_%0d", i), obs, 8'b1000_0001);
        end
        hold_req = 1'b0;
        tick();
        check("unpark_k237", obs, 8'b0101_0001);

        // Asynchronous reset in the middle of Q2.
        tick_to(244);
        check("mid_q2_k244", obs, 8'b0010_0001);
        #2;
        resetb = 1'b0;
        #1;
        check("async_rst_div3", obs, 8'b0);
        check("async_rst_div1", obs1, 8'b0);
        repeat (3) tick();
        release_reset();
        run_table();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
